buzzer_sound_scheduler: RTL

//  Arbitrates the door-lock FSM's sound requests (key click, open chime, error, lockout, pipo alarm) onto
//  one shared tone generator. Sequences each melody note-by-note as a 4-bit tone code.

---
 rtl/buzzer_sound_pkg.sv | 45 ++++
 rtl/buzzer_melody_rom.sv | 57 +++++
 rtl/buzzer_sound_scheduler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/buzzer_sound_pkg.sv
// Shared melody IDs, tone codes, melody length/loop tables and scheduler state encoding
// for the door-lock buzzer sound scheduler.
package buzzer_sound_pkg;

  typedef enum logic [2:0] {
    MEL_NONE = 3'd0,
    MEL_KEY  = 3'd1,
    MEL_OPEN = 3'd2,
    MEL_ERR  = 3'd3,
    MEL_LOCK = 3'd4,
    MEL_PIPO = 3'd5
  } melody_e;

  localparam logic [3:0] TONE_OFF   = 4'd0;
  localparam logic [3:0] TONE_C     = 4'd1;
  localparam logic [3:0] TONE_E     = 4'd2;
  localparam logic [3:0] TONE_FS    = 4'd3;
  localparam logic [3:0] TONE_G     = 4'd4;
  localparam logic [3:0] TONE_GS    = 4'd5;
  localparam logic [3:0] TONE_HI_AS = 4'd6;
  localparam logic [3:0] TONE_HI_B  = 4'd7;
  localparam logic [3:0] TONE_HI_C  = 4'd8;
  localparam logic [3:0] TONE_HI_E  = 4'd9;
  localparam logic [3:0] TONE_HI_G  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  function automatic logic [2:0] melLen(melody_e id);
    case (id)
      MEL_KEY:            return 3'd1;
      MEL_OPEN, MEL_ERR:  return 3'd3;
      MEL_LOCK, MEL_PIPO: return 3'd4;
      default:            return 3'd0;
    endcase
  endfunction

  function automatic logic melLoops(melody_e id);
    return (id == MEL_LOCK) || (id == MEL_PIPO);
  endfunction

endpackage

// File: rtl/buzzer_melody_rom.sv
// Combinational melody table: (melody, note index) -> tone code, plus whether this is the
// melody's last note and whether the melody loops.
module buzzer_melody_rom
  import buzzer_sound_pkg::*;
(
  input  melody_e    melody_id_i,
  input  logic [1:0] note_idx_i,
  output logic [3:0] tone_code_o,
  output logic       last_note_o,
  output logic       loops_o
);

  always_comb begin
    tone_code_o = TONE_OFF;
    case (melody_id_i)
      MEL_KEY: begin
        if (note_idx_i == 2'd0) tone_code_o = TONE_C;
      end
      MEL_OPEN: begin
        case (note_idx_i)
          2'd0:    tone_code_o = TONE_E;
          2'd1:    tone_code_o = TONE_G;
          2'd2:    tone_code_o = TONE_HI_C;
          default: tone_code_o = TONE_OFF;
        endcase
      end
      MEL_ERR: begin
        case (note_idx_i)
          2'd0:    tone_code_o = TONE_HI_B;
          2'd1:    tone_code_o = TONE_HI_AS;
          2'd2:    tone_code_o = TONE_G;
          default: tone_code_o = TONE_OFF;
        endcase
      end
      MEL_LOCK: begin
        case (note_idx_i)
          2'd0:    tone_code_o = TONE_GS;
          2'd1:    tone_code_o = TONE_G;
          2'd2:    tone_code_o = TONE_FS;
          default: tone_code_o = TONE_G;
        endcase
      end
      MEL_PIPO: begin
        case (note_idx_i)
          2'd0, 2'd1: tone_code_o = TONE_HI_E;
          default:    tone_code_o = TONE_HI_G;
        endcase
      end
      default: tone_code_o = TONE_OFF;
    endcase
  end

  // MEL_NONE has length 0, so its "last index" becomes 7 and never matches.
  assign last_note_o = ({1'b0, note_idx_i} == (melLen(melody_id_i) - 3'd1));
  assign loops_o     = melLoops(melody_id_i);

endmodule

// File: rtl/buzzer_sound_scheduler.sv
// Arbitrates door-lock sound requests onto one tone generator and steps each melody note by note.
// Define BUZZER_NOTE_GAP_EN to insert GAP_TICKS silent cycles between notes.
module buzzer_sound_scheduler
  import buzzer_sound_pkg::*;
#(
  parameter int unsigned NOTE_TICKS = 5_000_000,
  parameter int unsigned GAP_TICKS  = 500_000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_req,
  input  logic       open_req,
  input  logic       err_req,
  input  logic       lock_req,
  input  logic       pipo_req,
  output logic [3:0] tone_code,
  output logic       busy,
  output logic [2:0] active_id,
  output logic       done
);

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

  state_e           state_q;
  melody_e          activeId_q;
  logic [1:0]       noteIdx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       tone_q;
  logic             busy_q;
  logic             done_q;

  logic keyPrev_q, openPrev_q, errPrev_q;
  logic keyPend_q, openPend_q, errPend_q;
  logic keyPend_d, openPend_d, errPend_d;

  logic       keyRise, openRise, errRise;
  logic       oneShotPend, activeLevel;
  logic       grant, preempt, levelDrop, cntDone;
  melody_e    grantId, loadId;
  logic [1:0] nextIdx, loadIdx;
  logic [3:0] curTone, loadTone;
  logic       curLast, curLoops, loadLast, loadLoops;
  logic       unusedRomBits;

  assign keyRise  = key_req & ~keyPrev_q;
  assign openRise = open_req & ~openPrev_q;
  assign errRise  = err_req & ~errPrev_q;

  // Latched one-shots outrank the live level requests; levels are never latched.
  always_comb begin
    grantId = MEL_NONE;
    if (errPend_q)       grantId = MEL_ERR;
    else if (openPend_q) grantId = MEL_OPEN;
    else if (keyPend_q)  grantId = MEL_KEY;
    else if (lock_req)   grantId = MEL_LOCK;
    else if (pipo_req)   grantId = MEL_PIPO;
  end

  assign oneShotPend = keyPend_q | openPend_q | errPend_q;
  assign activeLevel = (activeId_q == MEL_LOCK) ? lock_req : pipo_req;
  assign preempt     = (state_q != ST_IDLE) && curLoops && oneShotPend;
  assign levelDrop   = (state_q != ST_IDLE) && curLoops && !activeLevel;
  assign grant       = ((state_q == ST_IDLE) && (grantId != MEL_NONE)) || preempt;
  assign cntDone     = (cnt_q == ((state_q == ST_GAP) ? GAP_LAST : NOTE_LAST));
  assign nextIdx     = curLast ? 2'd0 : noteIdx_q + 2'd1;

  // Leaving GAP the index was already advanced, so the load ROM reads it as-is.
  assign loadId  = grant ? grantId : activeId_q;
  assign loadIdx = grant ? 2'd0 : ((state_q == ST_GAP) ? noteIdx_q : nextIdx);

  // A rise on the grant cycle survives the clear, so a melody requested while playing replays.
  assign keyPend_d  = (keyPend_q  & ~(grant && (grantId == MEL_KEY)))  | keyRise;
  assign openPend_d = (openPend_q & ~(grant && (grantId == MEL_OPEN))) | openRise;
  assign errPend_d  = (errPend_q  & ~(grant && (grantId == MEL_ERR)))  | errRise;

  buzzer_melody_rom uCurRom (
    .melody_id_i (activeId_q),
    .note_idx_i  (noteIdx_q),
    .tone_code_o (curTone),
    .last_note_o (curLast),
    .loops_o     (curLoops)
  );

  buzzer_melody_rom uLoadRom (
    .melody_id_i (loadId),
    .note_idx_i  (loadIdx),
    .tone_code_o (loadTone),
    .last_note_o (loadLast),
    .loops_o     (loadLoops)
  );

  assign unusedRomBits = ^{curTone, loadLast, loadLoops};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      keyPrev_q  <= 1'b0;
      openPrev_q <= 1'b0;
      errPrev_q  <= 1'b0;
      keyPend_q  <= 1'b0;
      openPend_q <= 1'b0;
      errPend_q  <= 1'b0;
    end else begin
      keyPrev_q  <= key_req;
      openPrev_q <= open_req;
      errPrev_q  <= err_req;
      keyPend_q  <= keyPend_d;
      openPend_q <= openPend_d;
      errPend_q  <= errPend_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      activeId_q <= MEL_NONE;
      noteIdx_q  <= 2'd0;
      cnt_q      <= '0;
      tone_q     <= TONE_OFF;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tone_q <= TONE_OFF;
          if (grant) begin
            state_q    <= ST_PLAY;
            activeId_q <= grantId;
            noteIdx_q  <= 2'd0;
            cnt_q      <= '0;
            tone_q     <= loadTone;
            busy_q     <= 1'b1;
          end
        end
        default: begin
          if (preempt) begin
            state_q    <= ST_PLAY;
            activeId_q <= grantId;
            noteIdx_q  <= 2'd0;
            cnt_q      <= '0;
            tone_q     <= loadTone;
            busy_q     <= 1'b1;
          end else if (levelDrop) begin
            state_q    <= ST_IDLE;
            activeId_q <= MEL_NONE;
            noteIdx_q  <= 2'd0;
            cnt_q      <= '0;
            tone_q     <= TONE_OFF;
            busy_q     <= 1'b0;
          end else if (!cntDone) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else if (state_q == ST_GAP) begin
            state_q <= ST_PLAY;
            cnt_q   <= '0;
            tone_q  <= loadTone;
          end else if (curLast && !curLoops) begin
            state_q    <= ST_IDLE;
            activeId_q <= MEL_NONE;
            noteIdx_q  <= 2'd0;
            cnt_q      <= '0;
            tone_q     <= TONE_OFF;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end else begin
`ifdef BUZZER_NOTE_GAP_EN
            state_q <= ST_GAP;
            tone_q  <= TONE_OFF;
`else
            tone_q  <= loadTone;
`endif
            noteIdx_q <= nextIdx;
            cnt_q     <= '0;
          end
        end
      endcase
    end
  end

  assign tone_code = tone_q;
  assign busy      = busy_q;
  assign active_id = activeId_q;
  assign done      = done_q;

endmodule
